// File: rtl/sum_latch_ctrl.sv
// Front end of the sum-latch UART system: button conditioning, operand capture, A+B, and a start/busy send FSM.
// Build option: define ASCII_HEX_EN to send each sum as two uppercase ASCII hex digits plus CR instead of one raw byte.
module sum_latch_ctrl #(
  parameter int DATA_W          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              save_a_n,
  input  logic              save_b_n,
  input  logic [DATA_W-1:0] data_input,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [DATA_W-1:0] a_reg,
  output logic [DATA_W-1:0] b_reg,
  output logic [DATA_W:0]   sum_out
);

  localparam int SUM_W = DATA_W + 1;
  localparam logic [DB_CNT_W-1:0] DB_MAX = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Button index 0 is save A, index 1 is save B.
  logic [1:0]          btn_s1_q, btn_s1_d;
  logic [1:0]          btn_s2_q, btn_s2_d;
  logic [1:0]          btn_stable_q, btn_stable_d;
  logic [1:0]          press_q, press_d;
  logic [DB_CNT_W-1:0] db_cnt_q [2];
  logic [DB_CNT_W-1:0] db_cnt_d [2];
  logic [DATA_W-1:0]   data_s1_q, data_s1_d;
  logic [DATA_W-1:0]   data_s2_q, data_s2_d;

  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                b_load_q, b_load_d;
  logic                pending_q, pending_d;
  logic [7:0]          tx_data_q, tx_data_d;

  logic                tx_start_c;
  logic                first_byte;
  logic [7:0]          byte_now;

`ifdef ASCII_HEX_EN
  logic [1:0]          idx_q, idx_d;
  logic [SUM_W-1:0]    snap_q, snap_d;
  logic [SUM_W-1:0]    sum_src;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Later bytes of a frame use the snapshot so a mid-frame capture cannot split the digits.
  always_comb begin
    sum_src    = (idx_q == 2'd0) ? sum_q : snap_q;
    first_byte = (idx_q == 2'd0);
    case (idx_q)
      2'd0:    byte_now = hex_char(4'(sum_src >> 4));
      2'd1:    byte_now = hex_char(sum_src[3:0]);
      default: byte_now = 8'h0D;
    endcase
    snap_d = (tx_start_c && first_byte) ? sum_q : snap_q;
    idx_d  = idx_q;
    if (state_q == WAIT_DONE && !tx_busy) begin
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= '0;
      snap_q <= '0;
    end else begin
      idx_q  <= idx_d;
      snap_q <= snap_d;
    end
  end
`else
  always_comb begin
    first_byte = 1'b1;
    byte_now   = 8'(sum_q);
  end
`endif

  // Input conditioning, capture and pending bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    btn_s1_d  = {save_b_n, save_a_n};
    btn_s2_d  = btn_s1_q;
    data_s1_d = data_input;
    data_s2_d = data_s1_q;

    for (int i = 0; i < 2; i++) begin
      btn_stable_d[i] = btn_stable_q[i];
      db_cnt_d[i]     = '0;
      if (btn_s2_q[i] != btn_stable_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          btn_stable_d[i] = btn_s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_CNT_W'(1);
        end
      end
      press_d[i] = btn_stable_q[i] & ~btn_stable_d[i];
    end

    a_d      = press_q[0] ? data_s2_q : a_q;
    b_d      = press_q[1] ? data_s2_q : b_q;
    b_load_d = press_q[1];
    sum_d    = SUM_W'(a_q) + SUM_W'(b_q);

    // A capture landing on the same cycle as a start must survive, so set wins over clear.
    pending_d = pending_q;
    if (b_load_q) begin
      pending_d = 1'b1;
    end else if (tx_start_c && first_byte) begin
      pending_d = 1'b0;
    end

    tx_data_d = tx_start_c ? byte_now : tx_data_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pending_q) state_d = SEND;
      SEND:      if (!tx_busy)  state_d = WAIT_ACK;
      WAIT_ACK:  if (tx_busy)   state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef ASCII_HEX_EN
          state_d = (idx_q == 2'd2) ? IDLE : SEND;
`else
          state_d = IDLE;
`endif
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  // Start is gated by live busy so it can never coincide with a busy transmitter.
  always_comb begin
    tx_start_c = (state_q == SEND) && !tx_busy;
    tx_start   = tx_start_c;
    tx_data    = tx_start_c ? byte_now : tx_data_q;
    a_reg      = a_q;
    b_reg      = b_q;
    sum_out    = sum_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_s1_q     <= 2'b11;
      btn_s2_q     <= 2'b11;
      btn_stable_q <= 2'b11;
      press_q      <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      data_s1_q    <= '0;
      data_s2_q    <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      b_load_q     <= 1'b0;
      pending_q    <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
      btn_s1_q     <= btn_s1_d;
      btn_s2_q     <= btn_s2_d;
      btn_stable_q <= btn_stable_d;
      press_q      <= press_d;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
      data_s1_q    <= data_s1_d;
      data_s2_q    <= data_s2_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      b_load_q     <= b_load_d;
      pending_q    <= pending_d;
      tx_data_q    <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_sum_latch_ctrl.sv
// Directed bench for sum_latch_ctrl with a busy-for-20-clocks UART model; honours ASCII_HEX_EN when defined.
module tb_sum_latch_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       save_a_n, save_b_n;
  logic [3:0] data_input;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] a_reg, b_reg;
  logic [4:0] sum_out;

  logic       force_busy;
  int         model_cnt;
  int         start_cnt;
  int         viol;
  logic       prev_start;
  logic [7:0] log_q[$];
  int         total = 0;
  int         bad   = 0;

`ifdef ASCII_HEX_EN
  localparam int FB = 3;
`else
  localparam int FB = 1;
`endif

  always #5 clk = ~clk;

  sum_latch_ctrl #(.DATA_W(4), .DEBOUNCE_CYCLES(4), .DB_CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .save_a_n(save_a_n), .save_b_n(save_b_n),
    .data_input(data_input), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .a_reg(a_reg), .b_reg(b_reg), .sum_out(sum_out)
  );

  // UART model: busy rises one clock after tx_start and stays high for 20 clocks.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)            model_cnt <= 0;
    else if (tx_start)       model_cnt <= 20;
    else if (model_cnt != 0) model_cnt <= model_cnt - 1;
  end
  assign tx_busy = (model_cnt != 0) || force_busy;

  always @(negedge clk) begin
    if (reset_n) begin
      if (tx_start) begin
        log_q.push_back(tx_data);
        start_cnt++;
        if (tx_busy || prev_start) viol++;
      end
      prev_start = tx_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int btn, input logic [3:0] d, input int lo, input int hi);
    data_input = d;
    if (btn == 0) save_a_n = 1'b0; else save_b_n = 1'b0;
    tick(lo);
    if (btn == 0) save_a_n = 1'b1; else save_b_n = 1'b1;
    tick(hi);
  endtask

  task automatic wait_starts(input string tag, input int n);
    int budget = 400;
    while (start_cnt < n && budget > 0) begin
      tick(1);
      budget--;
    end
    if (start_cnt < n) check({tag, "_timeout"}, start_cnt, n);
  endtask

  task automatic wait_frames(input string tag, input int frames);
    int budget = 100;
    wait_starts(tag, frames * FB);
    while (tx_busy && budget > 0) begin
      tick(1);
      budget--;
    end
    tick(5);
  endtask

  function automatic logic [8:0] log_at(input int i);
    return (i < log_q.size()) ? {1'b0, log_q[i]} : 9'h1FF;
  endfunction

  // raw: expected binary byte; hi/lo: expected ASCII digits for the same sum.
  task automatic check_frame(input string tag, input int frame, input logic [7:0] raw,
                             input logic [7:0] hi, input logic [7:0] lo);
`ifdef ASCII_HEX_EN
    check({tag, "_hi"}, log_at(frame * 3),     {1'b0, hi});
    check({tag, "_lo"}, log_at(frame * 3 + 1), {1'b0, lo});
    check({tag, "_cr"}, log_at(frame * 3 + 2), 9'h00D);
`else
    check({tag, "_byte"}, log_at(frame), {1'b0, raw});
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    reset_n = 1'b0; save_a_n = 1'b1; save_b_n = 1'b1; data_input = 4'h0;
    force_busy = 1'b0; start_cnt = 0; viol = 0; prev_start = 1'b0;
    tick(3);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data",  tx_data,  0);
    check("rst_a",        a_reg,    0);
    check("rst_b",        b_reg,    0);
    check("rst_sum",      sum_out,  0);
    reset_n = 1'b1;
    tick(3);

    // 1: A=3 alone starts nothing; B=5 sends 8.
    press(0, 4'h3, 10, 10);
    check("t1_a", a_reg, 4'h3);
    check("t1_sum_a_only", sum_out, 5'h03);
    check("t1_a_no_start", start_cnt, 0);
    press(1, 4'h5, 10, 10);
    wait_frames("t1", 1);
    check("t1_b", b_reg, 4'h5);
    check("t1_sum", sum_out, 5'h08);
    check("t1_starts", start_cnt, FB);
    check_frame("t1", 0, 8'h08, 8'h30, 8'h38);

    // 2: bouncing B, only the final 10-clock low is accepted.
    data_input = 4'h7;
    for (int i = 0; i < 5; i++) begin
      save_b_n = 1'b0; tick(2);
      save_b_n = 1'b1; tick(2);
    end
    press(1, 4'h7, 10, 10);
    wait_frames("t2", 2);
    tick(40);
    check("t2_b", b_reg, 4'h7);
    check("t2_sum", sum_out, 5'h0A);
    check("t2_starts", start_cnt, 2 * FB);
    check_frame("t2", 1, 8'h0A, 8'h30, 8'h41);

    // 3: maximum operands.
    press(0, 4'hF, 10, 10);
    press(1, 4'hF, 10, 10);
    wait_frames("t3", 3);
    check("t3_sum", sum_out, 5'h1E);
    check_frame("t3", 2, 8'h1E, 8'h31, 8'h45);

    // 4: presses during a held-busy frame merge into a single follow-up frame.
    base = start_cnt;
    data_input = 4'h4;
    save_b_n = 1'b0;
    wait_starts("t4_first", base + 1);
    force_busy = 1'b1;
    save_b_n = 1'b1;
    tick(10);
    press(1, 4'h1, 10, 10);
    check("t4_sum_mid", sum_out, 5'h10);
    press(1, 4'h2, 10, 10);
    check("t4_held_starts", start_cnt, base + 1);
    check("t4_sum", sum_out, 5'h11);
    force_busy = 1'b0;
    wait_frames("t4", 5);
    tick(60);
    check("t4_starts", start_cnt, 5 * FB);
    check_frame("t4_f1", 3, 8'h13, 8'h31, 8'h33);
    check_frame("t4_f2", 4, 8'h11, 8'h31, 8'h31);

    // 5: externally held busy keeps the FSM in SEND.
    force_busy = 1'b1;
    press(1, 4'h3, 10, 10);
    tick(10);
    check("t5_hold_start", tx_start, 0);
    check("t5_hold_cnt", start_cnt, 5 * FB);
    force_busy = 1'b0;
    wait_frames("t5", 6);
    check_frame("t5", 5, 8'h12, 8'h31, 8'h32);

    // 6: reset in WAIT_DONE clears everything asynchronously and abandons the frame.
    data_input = 4'h5;
    save_b_n = 1'b0;
    wait_starts("t6_first", 6 * FB + 1);
    save_b_n = 1'b1;
    tick(5);
    #3 reset_n = 1'b0;
    #1;
    check("t6_tx_start", tx_start, 0);
    check("t6_tx_data",  tx_data,  0);
    check("t6_a",        a_reg,    0);
    check("t6_b",        b_reg,    0);
    check("t6_sum",      sum_out,  0);
    tick(2);
    reset_n = 1'b1;
    base = start_cnt;
    tick(80);
    check("t6_no_restart", start_cnt, base);

    check("protocol_violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
